// File: rtl/relu_requant_pipe_pkg.sv
// rtl/relu_requant_pipe_pkg.sv - shared widths, constants and config type for the requant pipe
package relu_requant_pipe_pkg;

    localparam int DEF_LANES   = 8;
    localparam int DEF_IN_W    = 16;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_MULT_W  = 16;
    localparam int DEF_SHIFT_W = 5;
    localparam int DEF_CNT_W   = 32;

    localparam int PROD_W  = DEF_IN_W + DEF_MULT_W + 1;
    localparam int RND_W   = PROD_W + 1;
    localparam int OUT_MAX = (2 ** (DEF_OUT_W - 1)) - 1;
    localparam int OUT_MIN = -(2 ** (DEF_OUT_W - 1));

    typedef struct packed {
        logic [DEF_MULT_W-1:0]  mult;
        logic [DEF_SHIFT_W-1:0] shift;
        logic                   relu;
    } cfg_t;

    // Signed x times zero-extended unsigned mult needs one extra bit over the sum of widths.
    function automatic int prod_w(input int in_w, input int mult_w);
        return in_w + mult_w + 1;
    endfunction

endpackage

// File: rtl/relu_requant_pipe_if.sv
// rtl/relu_requant_pipe_if.sv - input/output stream bundle for the requant pipe
interface relu_requant_pipe_if #(
    parameter int LANES   = relu_requant_pipe_pkg::DEF_LANES,
    parameter int IN_W    = relu_requant_pipe_pkg::DEF_IN_W,
    parameter int OUT_W   = relu_requant_pipe_pkg::DEF_OUT_W,
    parameter int MULT_W  = relu_requant_pipe_pkg::DEF_MULT_W,
    parameter int SHIFT_W = relu_requant_pipe_pkg::DEF_SHIFT_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*IN_W-1:0]    in_data;
    logic [MULT_W-1:0]        cfg_mult;
    logic [SHIFT_W-1:0]       cfg_shift;
    logic                     cfg_relu;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;
    logic [LANES-1:0]         out_sat;

    modport slave (
        input  in_valid, in_data, cfg_mult, cfg_shift, cfg_relu, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_data, cfg_mult, cfg_shift, cfg_relu, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/relu_requant_pipe_lane.sv
// rtl/relu_requant_pipe_lane.sv - one lane: multiply, rounding shift, ReLU/clip over 3 stages
module relu_requant_pipe_lane
    import relu_requant_pipe_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int MULT_W  = DEF_MULT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [IN_W-1:0]    x_i,
    input  logic [MULT_W-1:0]  mult_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               relu_i,
    output logic [OUT_W-1:0]   y_o,
    output logic               sat_o
);
    localparam int PW = prod_w(IN_W, MULT_W);
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] R_MAX = RW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] R_MIN = -R_MAX - RW'(1);

    logic signed [PW-1:0] x_ext, m_ext;
    logic signed [PW-1:0] p_d, p_q;
    logic signed [RW-1:0] rnd, sum, r_d, r_q;
    logic [OUT_W-1:0]     y_d, y_q;
    logic                 sat_d, sat_q;

    always_comb begin
        x_ext = PW'($signed(x_i));
        m_ext = PW'($signed({1'b0, mult_i}));
        p_d   = x_ext * m_ext;
    end

    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    always_comb begin
        rnd = '0;
        if (shift_i != '0) begin
            rnd = RW'(1) << (shift_i - SHIFT_W'(1));
        end
        sum = RW'(p_q) + rnd;
        r_d = sum >>> shift_i;
    end

    always_comb begin
        y_d   = r_q[OUT_W-1:0];
        sat_d = 1'b0;
        if (relu_i && r_q < 0) begin
            y_d = '0;
        end else if (r_q > R_MAX) begin
            y_d   = R_MAX[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (r_q < R_MIN) begin
            y_d   = R_MIN[OUT_W-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            r_q   <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
        end else if (en_i) begin
            p_q   <= p_d;
            r_q   <= r_d;
            y_q   <= y_d;
            sat_q <= sat_d;
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/relu_requant_pipe.sv
// rtl/relu_requant_pipe.sv - LANES-wide requantise stage: valid chain, config pipe, saturation counter
module relu_requant_pipe
    import relu_requant_pipe_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int MULT_W  = DEF_MULT_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    relu_requant_pipe_if.slave bus,
    input  logic               sat_clr,
    output logic [CNT_W-1:0]   sat_count
);
    localparam int PW    = prod_w(IN_W, MULT_W);
    localparam int POP_W = $clog2(LANES + 1);

    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        logic               relu;
    } stage_cfg_t;

    logic             advance;
    logic             v1_q, v2_q, v3_q;
    stage_cfg_t       cfg1_q;
    logic             relu2_q;
    logic [OUT_W-1:0] y_lane [LANES];
    logic [LANES-1:0] sat_lane;
    logic [POP_W-1:0] pop;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sat_count_d, sat_count_q;

    // Whole pipe moves as one; a stalled output freezes every stage behind it.
    assign advance      = ~v3_q | bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out_valid = v3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            cfg1_q  <= '0;
            relu2_q <= 1'b0;
        end else if (advance) begin
            v1_q    <= bus.in_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            cfg1_q  <= '{shift: bus.cfg_shift, relu: bus.cfg_relu};
            relu2_q <= cfg1_q.relu;
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        relu_requant_pipe_lane #(
            .IN_W   (IN_W),
            .OUT_W  (OUT_W),
            .MULT_W (MULT_W),
            .SHIFT_W(SHIFT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (advance),
            .x_i    (bus.in_data[j*IN_W +: IN_W]),
            .mult_i (bus.cfg_mult),
            .shift_i(cfg1_q.shift),
            .relu_i (relu2_q),
            .y_o    (y_lane[j]),
            .sat_o  (sat_lane[j])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int j = 0; j < LANES; j++) begin
            bus.out_data[j*OUT_W +: OUT_W] = y_lane[j];
        end
    end

    assign bus.out_sat = sat_lane;

    always_comb begin
        pop = '0;
        for (int j = 0; j < LANES; j++) begin
            pop = pop + POP_W'(sat_lane[j]);
        end
        sum         = {1'b0, sat_count_q} + (CNT_W+1)'(pop);
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (v3_q && bus.out_ready) begin
            sat_count_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;

    a_shift_legal: assert property (@(posedge clk) disable iff (rst)
        (bus.in_valid && bus.in_ready) |-> (int'(bus.cfg_shift) < PW));

endmodule
